// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg
//   Shared definitions for the decode queue: instruction-type codes (including
//   ILLEGAL_INST and the M-extension codes), RV32 opcode/funct7 constants,
//   register-id and immediate widths, and the decoded-field record stored per
//   queue entry.
//   Optional feature macro used by the importing files: RV32M_EN.
package decode_queue_pkg;

   localparam int INST_W   = 32;
   localparam int REG_ID_W = 5;
   localparam int IMM_W    = 32;
   localparam int TYPE_W   = 6;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct7 values that select instruction variants
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [TYPE_W-1:0] {
      ILLEGAL_INST = 6'd0,
      IT_LUI       = 6'd1,
      IT_AUIPC     = 6'd2,
      IT_JAL       = 6'd3,
      IT_JALR      = 6'd4,
      IT_BEQ       = 6'd5,
      IT_BNE       = 6'd6,
      IT_BLT       = 6'd7,
      IT_BGE       = 6'd8,
      IT_BLTU      = 6'd9,
      IT_BGEU      = 6'd10,
      IT_LB        = 6'd11,
      IT_LH        = 6'd12,
      IT_LW        = 6'd13,
      IT_LBU       = 6'd14,
      IT_LHU       = 6'd15,
      IT_SB        = 6'd16,
      IT_SH        = 6'd17,
      IT_SW        = 6'd18,
      IT_ADDI      = 6'd19,
      IT_SLTI      = 6'd20,
      IT_SLTIU     = 6'd21,
      IT_XORI      = 6'd22,
      IT_ORI       = 6'd23,
      IT_ANDI      = 6'd24,
      IT_SLLI      = 6'd25,
      IT_SRLI      = 6'd26,
      IT_SRAI      = 6'd27,
      IT_ADD       = 6'd28,
      IT_SUB       = 6'd29,
      IT_SLL       = 6'd30,
      IT_SLT       = 6'd31,
      IT_SLTU      = 6'd32,
      IT_XOR       = 6'd33,
      IT_SRL       = 6'd34,
      IT_SRA       = 6'd35,
      IT_OR        = 6'd36,
      IT_AND       = 6'd37,
      IT_MUL       = 6'd38,
      IT_MULH      = 6'd39,
      IT_MULHSU    = 6'd40,
      IT_MULHU     = 6'd41,
      IT_DIV       = 6'd42,
      IT_DIVU      = 6'd43,
      IT_REM       = 6'd44,
      IT_REMU      = 6'd45
   } inst_type_e;

   typedef struct packed {
      inst_type_e          itype;
      logic [REG_ID_W-1:0] rd;
      logic [REG_ID_W-1:0] rs1;
      logic [REG_ID_W-1:0] rs2;
      logic [IMM_W-1:0]    imm;
      logic                illegal;
   } dec_fields_t;

endpackage

// File: rtl/inst_decode_core.sv
// inst_decode_core
//   Purely combinational RV32I decoder (plus RV32M when RV32M_EN is defined).
//   Produces the instruction type, register ids (zeroed where the format does
//   not use them), the sign-extended 32-bit immediate and an illegal flag.
//   Any unlisted opcode/funct3/funct7 yields ILLEGAL_INST with all fields 0.
//   Ports:
//     inst_i : raw 32-bit instruction
//     dec_o  : decoded fields (dec_fields_t)
//   Macro: RV32M_EN enables MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
module inst_decode_core
   import decode_queue_pkg::*;
(
   input  logic [INST_W-1:0] inst_i,
   output dec_fields_t       dec_o
);

   function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
      return {{(IMM_W-12){v[11]}}, v};
   endfunction

   function automatic logic [IMM_W-1:0] sext13(input logic [12:0] v);
      return {{(IMM_W-13){v[12]}}, v};
   endfunction

   function automatic logic [IMM_W-1:0] sext21(input logic [20:0] v);
      return {{(IMM_W-21){v[20]}}, v};
   endfunction

   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

   assign opcode = inst_i[6:0];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];

   assign imm_i  = sext12(inst_i[31:20]);
   assign imm_s  = sext12({inst_i[31:25], inst_i[11:7]});
   assign imm_b  = sext13({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
   assign imm_j  = sext21({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});
   assign imm_u  = {inst_i[31:12], 12'b0};
   assign imm_sh = {{(IMM_W-5){1'b0}}, inst_i[24:20]};

   inst_type_e       itype;
   logic             use_rd, use_rs1, use_rs2, illegal;
   logic [IMM_W-1:0] imm;

   always_comb begin
      itype   = ILLEGAL_INST;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      imm     = '0;
      case (opcode)
         OPC_LUI: begin
            itype  = IT_LUI;
            use_rd = 1'b1;
            imm    = imm_u;
         end
         OPC_AUIPC: begin
            itype  = IT_AUIPC;
            use_rd = 1'b1;
            imm    = imm_u;
         end
         OPC_JAL: begin
            itype  = IT_JAL;
            use_rd = 1'b1;
            imm    = imm_j;
         end
         OPC_JALR: begin
            if (f3 == 3'b000) itype = IT_JALR;
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm     = imm_i;
         end
         OPC_BRANCH: begin
            case (f3)
               3'b000:  itype = IT_BEQ;
               3'b001:  itype = IT_BNE;
               3'b100:  itype = IT_BLT;
               3'b101:  itype = IT_BGE;
               3'b110:  itype = IT_BLTU;
               3'b111:  itype = IT_BGEU;
               default: itype = ILLEGAL_INST;
            endcase
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_b;
         end
         OPC_LOAD: begin
            case (f3)
               3'b000:  itype = IT_LB;
               3'b001:  itype = IT_LH;
               3'b010:  itype = IT_LW;
               3'b100:  itype = IT_LBU;
               3'b101:  itype = IT_LHU;
               default: itype = ILLEGAL_INST;
            endcase
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm     = imm_i;
         end
         OPC_STORE: begin
            case (f3)
               3'b000:  itype = IT_SB;
               3'b001:  itype = IT_SH;
               3'b010:  itype = IT_SW;
               default: itype = ILLEGAL_INST;
            endcase
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_s;
         end
         OPC_OP_IMM: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm     = imm_i;
            case (f3)
               3'b000: itype = IT_ADDI;
               3'b010: itype = IT_SLTI;
               3'b011: itype = IT_SLTIU;
               3'b100: itype = IT_XORI;
               3'b110: itype = IT_ORI;
               3'b111: itype = IT_ANDI;
               3'b001: begin
                  imm = imm_sh;
                  if (f7 == F7_BASE) itype = IT_SLLI;
               end
               default: begin
                  // funct3=101: inst[30] selects arithmetic vs logical shift
                  imm = imm_sh;
                  if (f7 == F7_BASE)     itype = IT_SRLI;
                  else if (f7 == F7_ALT) itype = IT_SRAI;
               end
            endcase
         end
         OPC_OP: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (f7 == F7_BASE) begin
               case (f3)
                  3'b000:  itype = IT_ADD;
                  3'b001:  itype = IT_SLL;
                  3'b010:  itype = IT_SLT;
                  3'b011:  itype = IT_SLTU;
                  3'b100:  itype = IT_XOR;
                  3'b101:  itype = IT_SRL;
                  3'b110:  itype = IT_OR;
                  default: itype = IT_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               if (f3 == 3'b000)      itype = IT_SUB;
               else if (f3 == 3'b101) itype = IT_SRA;
            end
`ifdef RV32M_EN
            else if (f7 == F7_MULDIV) begin
               case (f3)
                  3'b000:  itype = IT_MUL;
                  3'b001:  itype = IT_MULH;
                  3'b010:  itype = IT_MULHSU;
                  3'b011:  itype = IT_MULHU;
                  3'b100:  itype = IT_DIV;
                  3'b101:  itype = IT_DIVU;
                  3'b110:  itype = IT_REM;
                  default: itype = IT_REMU;
               endcase
            end
`endif
         end
         default: itype = ILLEGAL_INST;
      endcase
   end

   // An illegal encoding clears every field so nothing downstream can act on it.
   assign illegal       = (itype == ILLEGAL_INST);
   assign dec_o.itype   = itype;
   assign dec_o.illegal = illegal;
   assign dec_o.rd      = (use_rd  && !illegal) ? inst_i[11:7]  : '0;
   assign dec_o.rs1     = (use_rs1 && !illegal) ? inst_i[19:15] : '0;
   assign dec_o.rs2     = (use_rs2 && !illegal) ? inst_i[24:20] : '0;
   assign dec_o.imm     = illegal ? '0 : imm;

endmodule

// File: rtl/decode_queue.sv
// decode_queue
//   FIFO of decoded instructions. Each instruction is decoded as it is pushed
//   (inst_decode_core) and only the decoded fields plus PC are stored. The head
//   entry is presented from registers one cycle after the push.
//   Ports:
//     clk_in, rst_n_in           : clock, asynchronous active-low reset
//     flush_in                   : drop all queued and same-cycle incoming entries
//     in_valid_in / in_ready_out : upstream handshake, in_inst_in / in_pc_in payload
//     out_valid_out / out_ready_in : downstream handshake
//     out_inst_type_out, out_rd_out, out_rs1_out, out_rs2_out, out_imm_out,
//     out_pc_out, out_illegal_out : head entry (all zero when empty)
//     count_out                  : occupancy
//   Macro: RV32M_EN (passed through to the decoder).
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      flush_in,
   input  logic                      in_valid_in,
   output logic                      in_ready_out,
   input  logic [INST_W-1:0]         in_inst_in,
   input  logic [PC_W-1:0]           in_pc_in,
   output logic                      out_valid_out,
   input  logic                      out_ready_in,
   output logic [TYPE_W-1:0]         out_inst_type_out,
   output logic [REG_ID_W-1:0]       out_rd_out,
   output logic [REG_ID_W-1:0]       out_rs1_out,
   output logic [REG_ID_W-1:0]       out_rs2_out,
   output logic [IMM_W-1:0]          out_imm_out,
   output logic [PC_W-1:0]           out_pc_out,
   output logic                      out_illegal_out,
   output logic [$clog2(DEPTH):0]    count_out
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      dec_fields_t     dec;
      logic [PC_W-1:0] pc;
   } entry_t;

   dec_fields_t   dec_w;
   entry_t        mem_q [DEPTH];
   entry_t        head;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   inst_decode_core u_core (
      .inst_i (in_inst_in),
      .dec_o  (dec_w)
   );

   // Ready depends only on registered occupancy: no path from out_ready_in.
   assign in_ready_out  = (count_q < FULL_CNT);
   assign out_valid_out = (count_q != '0);

   // Flush suppresses both handshakes in the same cycle.
   assign push = in_valid_in && in_ready_out && !flush_in;
   assign pop  = out_valid_out && out_ready_in && !flush_in;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_in) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_in) begin
      if (push) mem_q[wptr_q] <= {dec_w, in_pc_in};
   end

   // Empty (including during reset) presents an all-zero head.
   assign head = out_valid_out ? mem_q[rptr_q] : '0;

   assign out_inst_type_out = head.dec.itype;
   assign out_rd_out        = head.dec.rd;
   assign out_rs1_out       = head.dec.rs1;
   assign out_rs2_out       = head.dec.rs2;
   assign out_imm_out       = head.dec.imm;
   assign out_illegal_out   = head.dec.illegal;
   assign out_pc_out        = head.pc;
   assign count_out         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Scoreboard bench for decode_queue. Accepted pushes are decoded by a
//   table-driven reference model and queued; a monitor compares the DUT head,
//   occupancy and handshake outputs against that queue every cycle.
//   Macro: RV32M_EN selects whether M-extension encodings are expected legal.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [5:0]  t;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
      logic [31:0] pc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_ill;
   logic [31:0]     in_inst, in_pc, out_imm, out_pc;
   logic [5:0]      out_type;
   logic [4:0]      out_rd, out_rs1, out_rs2;
   logic [CW-1:0]   count;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sbq[$];
   exp_t pend;
   bit   pend_push, pend_flush;

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .flush_in          (flush),
      .in_valid_in       (in_valid),
      .in_ready_out      (in_ready),
      .in_inst_in        (in_inst),
      .in_pc_in          (in_pc),
      .out_valid_out     (out_valid),
      .out_ready_in      (out_ready),
      .out_inst_type_out (out_type),
      .out_rd_out        (out_rd),
      .out_rs1_out       (out_rs1),
      .out_rs2_out       (out_rs2),
      .out_imm_out       (out_imm),
      .out_pc_out        (out_pc),
      .out_illegal_out   (out_ill),
      .count_out         (count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int sx(input int v, input int bits);
      if (v >= (1 << (bits - 1))) return v - (1 << bits);
      return v;
   endfunction

   // Reference decode: format chosen by opcode, type looked up by funct3 tables.
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      exp_t       e;
      inst_type_e t;
      int         imm;
      bit         urd, urs1, urs2;
      int         f3, f7;
      inst_type_e br[8], ld[8], st[8], oi[8], rb[8], ra[8], rm[8];
      br = '{IT_BEQ, IT_BNE, ILLEGAL_INST, ILLEGAL_INST, IT_BLT, IT_BGE, IT_BLTU, IT_BGEU};
      ld = '{IT_LB, IT_LH, IT_LW, ILLEGAL_INST, IT_LBU, IT_LHU, ILLEGAL_INST, ILLEGAL_INST};
      st = '{IT_SB, IT_SH, IT_SW, ILLEGAL_INST, ILLEGAL_INST, ILLEGAL_INST, ILLEGAL_INST, ILLEGAL_INST};
      oi = '{IT_ADDI, IT_SLLI, IT_SLTI, IT_SLTIU, IT_XORI, IT_SRLI, IT_ORI, IT_ANDI};
      rb = '{IT_ADD, IT_SLL, IT_SLT, IT_SLTU, IT_XOR, IT_SRL, IT_OR, IT_AND};
      ra = '{IT_SUB, ILLEGAL_INST, ILLEGAL_INST, ILLEGAL_INST, ILLEGAL_INST, IT_SRA, ILLEGAL_INST, ILLEGAL_INST};
      rm = '{IT_MUL, IT_MULH, IT_MULHSU, IT_MULHU, IT_DIV, IT_DIVU, IT_REM, IT_REMU};
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      t = ILLEGAL_INST; imm = 0; urd = 0; urs1 = 0; urs2 = 0;
      case (w[6:0])
         7'b0110111: begin t = IT_LUI;   urd = 1; imm = int'(w[31:12]) << 12; end
         7'b0010111: begin t = IT_AUIPC; urd = 1; imm = int'(w[31:12]) << 12; end
         7'b1101111: begin
            t = IT_JAL; urd = 1;
            imm = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12)
                     + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
         end
         7'b1100111: begin
            if (f3 == 0) t = IT_JALR;
            urd = 1; urs1 = 1; imm = sx(int'(w[31:20]), 12);
         end
         7'b1100011: begin
            t = br[f3]; urs1 = 1; urs2 = 1;
            imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                     + int'(w[11:8]) * 2, 13);
         end
         7'b0000011: begin t = ld[f3]; urd = 1; urs1 = 1; imm = sx(int'(w[31:20]), 12); end
         7'b0100011: begin
            t = st[f3]; urs1 = 1; urs2 = 1;
            imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
         end
         7'b0010011: begin
            t = oi[f3]; urd = 1; urs1 = 1; imm = sx(int'(w[31:20]), 12);
            if (f3 == 1 || f3 == 5) begin
               imm = int'(w[24:20]);
               if (f3 == 1 && f7 != 0) t = ILLEGAL_INST;
               if (f3 == 5) t = (f7 == 0) ? IT_SRLI : ((f7 == 32) ? IT_SRAI : ILLEGAL_INST);
            end
         end
         7'b0110011: begin
            urd = 1; urs1 = 1; urs2 = 1;
            if (f7 == 0)       t = rb[f3];
            else if (f7 == 32) t = ra[f3];
`ifdef RV32M_EN
            else if (f7 == 1)  t = rm[f3];
`endif
         end
         default: t = ILLEGAL_INST;
      endcase
      e     = '0;
      e.pc  = pc;
      e.t   = t;
      e.ill = (t == ILLEGAL_INST);
      if (!e.ill) begin
         e.imm = imm;
         e.rd  = urd  ? w[11:7]  : 5'd0;
         e.rs1 = urs1 ? w[19:15] : 5'd0;
         e.rs2 = urs2 ? w[24:20] : 5'd0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [31:0] w;
      logic [6:0]  ops[9];
      int          k;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = ops[k];
      if (k == 7 || k == 8) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end
      return w;
   endfunction

   // Stimulus side: record what the DUT will accept at the coming edge.
   always @(negedge clk) begin
      pend_flush = rst_n && flush;
      pend_push  = rst_n && in_valid && in_ready && !flush;
      pend       = ref_decode(in_inst, in_pc);
   end

   always @(posedge clk) begin
      if (!rst_n || pend_flush) sbq.delete();
      else if (pend_push) sbq.push_back(pend);
   end

   // Monitor: compare occupancy, handshakes and head against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("count", count, sbq.size());
         chk("out_valid", out_valid, sbq.size() != 0);
         chk("in_ready", in_ready, sbq.size() < DEPTH);
         if (out_valid && sbq.size() > 0) begin
            chk("head_type", out_type, sbq[0].t);
            chk("head_rd", out_rd, sbq[0].rd);
            chk("head_rs1", out_rs1, sbq[0].rs1);
            chk("head_rs2", out_rs2, sbq[0].rs2);
            chk("head_imm", out_imm, sbq[0].imm);
            chk("head_ill", out_ill, sbq[0].ill);
            chk("head_pc", out_pc, sbq[0].pc);
            if (out_ready && !flush) void'(sbq.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] w);
      in_valid = 1'b1;
      in_inst  = w;
      in_pc    = $urandom;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && count != 0; i++) cyc();
      chk("drain_empty", count, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] ops[5];
      ops = '{32'h00500093, 32'h4020D093, 32'h123452B7, 32'h00A00113, 32'h00B00193};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      #2;
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_data", {out_type, out_rd, out_rs1, out_rs2, out_ill}, 0);
      chk("rst_imm_pc", {out_imm, out_pc}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();

      push_one(32'h00500093);
      chk("addi_valid", out_valid, 1);
      chk("addi_type", out_type, IT_ADDI);
      chk("addi_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd0});
      chk("addi_imm", out_imm, 5);
      chk("addi_ill", out_ill, 0);
      drain();

      push_one(32'h4020D093);
      chk("srai_type", out_type, IT_SRAI);
      chk("srai_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd1});
      chk("srai_imm", out_imm, 2);
      drain();

      push_one(32'h123452B7);
      chk("lui_type", out_type, IT_LUI);
      chk("lui_rd", out_rd, 5);
      chk("lui_imm", out_imm, 32'h12345000);
      drain();

      // Fill to DEPTH with the consumer stalled, then offer a fifth entry.
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_inst = ops[k];
         in_pc   = 32'h1000 + 4 * k;
         cyc();
      end
      chk("full_ready", in_ready, 0);
      chk("full_count", count, 4);
      in_inst = ops[4];
      in_pc   = 32'h1010;
      cyc();
      chk("stall_count", count, 4);
      in_valid = 1'b0;
      drain();

      // Flush at count 3 with a simultaneous push and pop.
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_inst = ops[k];
         in_pc   = 32'h2000 + 4 * k;
         cyc();
      end
      in_valid = 1'b0;
      chk("pre_flush_count", count, 3);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_inst = 32'h06300213;
      cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 0);
      repeat (3) cyc();
      chk("flush_no_ghost", {out_valid, count}, 0);

      push_one(32'h02208033);
`ifdef RV32M_EN
      chk("mul_type", out_type, IT_MUL);
      chk("mul_rs", {out_rs1, out_rs2, out_ill}, {5'd1, 5'd2, 1'b0});
`else
      chk("mul_type", out_type, ILLEGAL_INST);
      chk("mul_ill", out_ill, 1);
`endif
      drain();

      push_one(32'hFFFFFFFF);
      chk("ill_flag", out_ill, 1);
      chk("ill_type", out_type, ILLEGAL_INST);
      chk("ill_fields", {out_rd, out_rs1, out_rs2, out_imm}, 0);

      // Randomised traffic with an asynchronous reset pulse in the middle.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         in_inst   = gen_inst();
         in_pc     = $urandom;
         if (i == 300) begin
            #2 rst_n = 1'b0;
            #1;
            chk("arst_count", count, 0);
            chk("arst_valid_ready", {out_valid, in_ready}, 2'b01);
            chk("arst_data", {out_type, out_rd, out_imm, out_pc}, 0);
         end
         cyc();
         if (i == 300) rst_n = 1'b1;
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning decoded-entry queue depth (power of two, >=2).
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the carried program counter.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush_in  input  1  discard all queued and incoming entries.
REQ-006 SHALL have ports in_valid_in  input  1  and in_ready_out  output  1  for the upstream handshake.
REQ-007 SHALL have ports in_inst_in  input  32  (raw instruction) and in_pc_in  input  PC_W  (its PC).
REQ-008 SHALL have ports out_valid_out  output  1  and out_ready_in  input  1  for the downstream handshake.
REQ-009 SHALL have port out_inst_type_out  output  6  instruction type code.
REQ-010 SHALL have ports out_rd_out, out_rs1_out, out_rs2_out  output  5 each  register ids.
REQ-011 SHALL have ports out_imm_out  output  32  (sign-extended immediate) and out_pc_out  output  PC_W.
REQ-012 SHALL have ports out_illegal_out  output  1  and count_out  output  clog2(DEPTH)+1  (occupancy).

Function
REQ-013 SHALL decode each instruction at push and store decoded fields, not raw bits.
REQ-014 SHALL push when in_valid_in && in_ready_out; SHALL pop when out_valid_out && out_ready_in.
REQ-015 SHALL drive in_ready_out = (count < DEPTH), with no combinational path from out_ready_in.
REQ-016 SHALL drive out_valid_out = (count != 0) and present the head entry from registers; push-to-visible latency is 1 cycle.
REQ-017 SHALL allow simultaneous push and pop with count unchanged, including at full (pop frees nothing until the next cycle) and at empty (no pop occurs).
REQ-018 SHALL preserve FIFO order; pointers wrap modulo DEPTH.
REQ-019 SHALL, on flush_in, zero count and pointers at the next edge, drop any same-cycle push, and ignore same-cycle pop; flush has priority.
REQ-020 SHALL sign-extend every immediate to 32 bits.
- LUI/AUIPC: {inst[31:12], 12'b0}.
- JALR/loads/OP-IMM: inst[31:20].
- Shift immediates: zero-extended inst[24:20].
- S-type, B-type and J-type: standard split fields, with bit 0 = 0 for B and J.
REQ-021 SHALL decode OP-IMM funct3=101 as SRLI (inst[30]=0) or SRAI (inst[30]=1); funct3=001 as SLLI; R-type funct3=011 as SLTU.
REQ-022 SHALL force rd=0 for branches/stores and rs1/rs2=0 where unused.
REQ-023 SHALL flag out_illegal_out=1 with type ILLEGAL_INST (0) and rd=rs1=rs2=0, imm=0 for any unlisted opcode, funct3 or funct7.

Reset
REQ-024 SHALL, while rst_n_in=0, clear count and pointers asynchronously; outputs are count_out=0, out_valid_out=0 and in_ready_out=1, and all data outputs are 0.
REQ-025 SHALL discard in-flight entries on reset mid-operation and resume on the first edge after deassertion.

Configuration
REQ-026 SHALL, with RV32M_EN defined, decode opcode 0110011 funct7=0000001 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU by funct3.
REQ-027 SHALL, without RV32M_EN, treat those encodings as illegal per REQ-023.

Structure
REQ-028 SHALL take all inst_type codes (including ILLEGAL_INST and the M-extension codes), the opcode constants and the REG_ID/IMM widths from the shared config header/package.
REQ-029 SHALL instantiate one combinational sub-module, inst_decode_core, holding the full decode; queue logic stays in decode_queue.

Verification
REQ-030 SHALL cover: push 0x00500093 -> next cycle ADDI, rd=1, rs1=0, imm=5, illegal=0.
REQ-031 SHALL cover: push 0x4020D093 -> SRAI, rd=1, rs1=1, imm=2; push 0x123452B7 -> LUI, rd=5, imm=0x12345000.
REQ-032 SHALL cover: DEPTH=4, out_ready_in=0, push 5 distinct ops -> in_ready_out=0 after 4th, count_out=4, 5th stalls; then drain -> original order.
REQ-033 SHALL cover: count_out=3, assert flush_in with a push and a pop -> next cycle count_out=0, out_valid_out=0, pushed entry never appears.
REQ-034 SHALL cover: push 0x02208033 -> MUL, rs1=1, rs2=2 with RV32M_EN; illegal=1, type 0 without it.
REQ-035 SHALL cover: push 0xFFFFFFFF -> out_illegal_out=1, type ILLEGAL_INST; rst_n_in pulsed low mid-stream -> count_out=0 immediately.
